vm_serializer: RTL and testbench

VM_SERIALIZER -- requirements
Module: vm_serializer

---
 rtl/vm_serializer.sv | 91 +++++++++
 tb/tb_vm_serializer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vm_serializer.sv
// Parallel-frame to time-multiplexed sample serializer with a free-running
// periodic sync pulse and a count of completely emitted frames.
module vm_serializer #(
  parameter int NR_CHANNELS = 4,
  parameter int INPUT_WIDTH = 24,
  parameter int SYNC_PERIOD = 48000,
  localparam int CHANNEL_WIDTH = (NR_CHANNELS > 1) ? $clog2(NR_CHANNELS) : 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NR_CHANNELS*INPUT_WIDTH-1:0] s_frame_d,
  input  logic                               s_frame_dv,
  output logic                               s_frame_ready,
  output logic [INPUT_WIDTH-1:0]             vm_signal_d,
  output logic [CHANNEL_WIDTH-1:0]           vm_signal_ch,
  output logic                               vm_signal_dv,
  output logic                               vm_sync,
  output logic [15:0]                        frame_count
);

  // state | meaning
  // IDLE  | frame buffer empty, ready for a new frame
  // SEND  | emitting buffered channels, one per cycle

  localparam int SYNC_W = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD) : 1;
  localparam logic [SYNC_W-1:0]        SYNC_LAST = SYNC_W'(SYNC_PERIOD - 1);
  localparam logic [CHANNEL_WIDTH-1:0] LAST_CH   = CHANNEL_WIDTH'(NR_CHANNELS - 1);

  if (NR_CHANNELS < 1 || NR_CHANNELS > 255 || SYNC_PERIOD < 1) begin : g_param_err
    $fatal(1, "vm_serializer: illegal parameters NR_CHANNELS=%0d SYNC_PERIOD=%0d",
           NR_CHANNELS, SYNC_PERIOD);
  end

  typedef enum logic {IDLE, SEND} state_t;

  state_t                           state;
  logic [NR_CHANNELS*INPUT_WIDTH-1:0] frame_buf;
  logic [SYNC_W-1:0]                sync_cnt;
  logic [SYNC_W-1:0]                sync_cnt_nxt;
  logic [CHANNEL_WIDTH-1:0]         next_ch;
  logic                             accept;
  logic                             last_ch;

  // vm_signal_ch doubles as the emission index while in SEND
  always_comb begin
    accept       = s_frame_ready & s_frame_dv;
    last_ch      = (state == SEND) && (vm_signal_ch == LAST_CH);
    next_ch      = vm_signal_ch + 1'b1;
    sync_cnt_nxt = (sync_cnt == SYNC_LAST) ? '0 : sync_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      frame_buf     <= '0;
      sync_cnt      <= '0;
      vm_sync       <= 1'b0;
      frame_count   <= '0;
      s_frame_ready <= 1'b0;
      vm_signal_d   <= '0;
      vm_signal_ch  <= '0;
      vm_signal_dv  <= 1'b0;
    end else begin
      sync_cnt <= sync_cnt_nxt;
      vm_sync  <= (sync_cnt_nxt == SYNC_LAST);

      if (last_ch)
        frame_count <= frame_count + 16'd1;

      if (accept) begin
        // channel 0 goes straight out of the input so the buffer adds no latency
        frame_buf     <= s_frame_d;
        vm_signal_d   <= s_frame_d[INPUT_WIDTH-1:0];
        vm_signal_ch  <= '0;
        vm_signal_dv  <= 1'b1;
        state         <= SEND;
        s_frame_ready <= (NR_CHANNELS == 1);
      end else if (state == SEND && !last_ch) begin
        vm_signal_d   <= frame_buf[next_ch*INPUT_WIDTH +: INPUT_WIDTH];
        vm_signal_ch  <= next_ch;
        vm_signal_dv  <= 1'b1;
        s_frame_ready <= (next_ch == LAST_CH);
      end else begin
        vm_signal_dv  <= 1'b0;
        state         <= IDLE;
        s_frame_ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vm_serializer.sv
// Directed bench for vm_serializer: a 4-channel instance with a short sync
// period, plus a 1-channel instance used for the frame_count wrap.
module tb_vm_serializer;
  localparam int NC  = 4;
  localparam int IW  = 24;
  localparam int SP  = 8;
  localparam int IW1 = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NC*IW-1:0]  s_frame_d = '0;
  logic              s_frame_dv = 1'b0;
  logic              s_frame_ready;
  logic [IW-1:0]     vm_signal_d;
  logic [1:0]        vm_signal_ch;
  logic              vm_signal_dv;
  logic              vm_sync;
  logic [15:0]       frame_count;

  logic [IW1-1:0]    s_frame_d1 = '0;
  logic              s_frame_dv1 = 1'b0;
  logic              s_frame_ready1;
  logic [IW1-1:0]    vm_signal_d1;
  logic [0:0]        vm_signal_ch1;
  logic              vm_signal_dv1;
  logic              vm_sync1;
  logic [15:0]       frame_count1;

  int checks = 0;
  int errors = 0;
  int exp_fc = 0;

  always #5 clk = ~clk;

  vm_serializer #(.NR_CHANNELS(NC), .INPUT_WIDTH(IW), .SYNC_PERIOD(SP)) dut (
    .clk(clk), .rst_n(rst_n), .s_frame_d(s_frame_d), .s_frame_dv(s_frame_dv),
    .s_frame_ready(s_frame_ready), .vm_signal_d(vm_signal_d), .vm_signal_ch(vm_signal_ch),
    .vm_signal_dv(vm_signal_dv), .vm_sync(vm_sync), .frame_count(frame_count)
  );

  vm_serializer #(.NR_CHANNELS(1), .INPUT_WIDTH(IW1), .SYNC_PERIOD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .s_frame_d(s_frame_d1), .s_frame_dv(s_frame_dv1),
    .s_frame_ready(s_frame_ready1), .vm_signal_d(vm_signal_d1), .vm_signal_ch(vm_signal_ch1),
    .vm_signal_dv(vm_signal_dv1), .vm_sync(vm_sync1), .frame_count(frame_count1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [IW-1:0] chv(input logic [NC*IW-1:0] f, input int k);
    return f[k*IW +: IW];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; s_frame_dv = 1'b0; s_frame_dv1 = 1'b0;
    tick(); tick();
    checks++;
    if ({s_frame_ready, vm_signal_dv, vm_sync} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: ready/dv/sync got %b expected 000",
                         {s_frame_ready, vm_signal_dv, vm_sync});
    end
    checks++;
    if (vm_signal_d !== '0 || vm_signal_ch !== '0 || frame_count !== '0) begin
      errors++; $display("FAIL reset_data: d=%h ch=%0d fc=%0d expected all 0",
                         vm_signal_d, vm_signal_ch, frame_count);
    end
    checks++;
    if ({s_frame_ready1, vm_signal_dv1, vm_sync1} !== 3'b000) begin
      errors++; $display("FAIL reset_dut1: ready/dv/sync got %b expected 000",
                         {s_frame_ready1, vm_signal_dv1, vm_sync1});
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (s_frame_ready !== 1'b1 || s_frame_ready1 !== 1'b1) begin
      errors++; $display("FAIL ready_after_reset: got %b%b expected 11", s_frame_ready, s_frame_ready1);
    end
    exp_fc = 0;
  endtask

  task automatic test_single_frame();
    logic [NC*IW-1:0] f;
    f = {24'h000004, 24'h800003, 24'h7FFFFF, 24'h000001};
    s_frame_d = f; s_frame_dv = 1'b1;
    tick();
    s_frame_dv = 1'b0; s_frame_d = '0;
    for (int k = 0; k < NC; k++) begin
      checks++;
      if (vm_signal_dv !== 1'b1 || vm_signal_ch !== 2'(k) || vm_signal_d !== chv(f, k)
          || s_frame_ready !== (k == NC-1)) begin
        errors++; $display("FAIL single k=%0d: dv=%b ch=%0d d=%h rdy=%b expected dv=1 ch=%0d d=%h rdy=%b",
                           k, vm_signal_dv, vm_signal_ch, vm_signal_d, s_frame_ready, k, chv(f, k), k == NC-1);
      end
      tick();
    end
    checks++;
    if (vm_signal_dv !== 1'b0 || frame_count !== 16'd1) begin
      errors++; $display("FAIL single_end: dv=%b fc=%0d expected dv=0 fc=1", vm_signal_dv, frame_count);
    end
    checks++;
    if (vm_signal_ch !== 2'd3 || vm_signal_d !== 24'h000004) begin
      errors++; $display("FAIL hold_idle: ch=%0d d=%h expected ch=3 d=000004", vm_signal_ch, vm_signal_d);
    end
    exp_fc = 1;
  endtask

  task automatic test_back_to_back();
    logic [NC*IW-1:0] fr [3];
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < NC; k++)
        fr[f][k*IW +: IW] = {8'(f + 16), 8'(k), 8'hC3};
    for (int c = 0; c <= 12; c++) begin
      if (c >= 1) begin
        int i;
        i = c - 1;
        checks++;
        if (vm_signal_dv !== 1'b1 || vm_signal_ch !== 2'(i % NC) || vm_signal_d !== chv(fr[i/NC], i % NC)) begin
          errors++; $display("FAIL b2b i=%0d: dv=%b ch=%0d d=%h expected dv=1 ch=%0d d=%h",
                             i, vm_signal_dv, vm_signal_ch, vm_signal_d, i % NC, chv(fr[i/NC], i % NC));
        end
      end
      s_frame_dv = (c <= 8);
      s_frame_d  = (c % NC == 0 && c <= 8) ? fr[c/NC] : {NC{24'hBADBAD}};
      tick();
    end
    s_frame_dv = 1'b0;
    exp_fc += 3;
    checks++;
    if (vm_signal_dv !== 1'b0 || frame_count !== 16'(exp_fc)) begin
      errors++; $display("FAIL b2b_end: dv=%b fc=%0d expected dv=0 fc=%0d", vm_signal_dv, frame_count, exp_fc);
    end
  endtask

  task automatic test_held_frame();
    logic [NC*IW-1:0] a, b;
    a = {24'hA00003, 24'hA00002, 24'hA00001, 24'hA00000};
    b = {24'hB00003, 24'hB00002, 24'hB00001, 24'hB00000};
    for (int c = 0; c <= 10; c++) begin
      if (c >= 1) begin
        int i;
        logic [IW-1:0] e;
        i = c - 1;
        e = (i < NC) ? chv(b, i) : chv(a, i - NC);
        checks++;
        if (i < 2*NC) begin
          if (vm_signal_dv !== 1'b1 || vm_signal_ch !== 2'(i % NC) || vm_signal_d !== e) begin
            errors++; $display("FAIL held i=%0d: dv=%b ch=%0d d=%h expected dv=1 ch=%0d d=%h",
                               i, vm_signal_dv, vm_signal_ch, vm_signal_d, i % NC, e);
          end
        end else if (vm_signal_dv !== 1'b0) begin
          errors++; $display("FAIL held_once i=%0d: dv=%b expected 0", i, vm_signal_dv);
        end
      end
      s_frame_dv = (c <= 4);
      s_frame_d  = (c == 0) ? b : a;
      tick();
    end
    s_frame_dv = 1'b0;
    exp_fc += 2;
    checks++;
    if (frame_count !== 16'(exp_fc)) begin
      errors++; $display("FAIL held_fc: got %0d expected %0d", frame_count, exp_fc);
    end
  endtask

  task automatic test_sync();
    rst_n = 1'b0; s_frame_dv = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    s_frame_d = {24'h000004, 24'h800003, 24'h7FFFFF, 24'h000001};
    for (int n = 0; n < 32; n++) begin
      checks++;
      if (vm_sync !== (n % SP == SP-1) || vm_sync1 !== (n >= 1)) begin
        errors++; $display("FAIL sync n=%0d: sync=%b sync1=%b expected %b %b",
                           n, vm_sync, vm_sync1, n % SP == SP-1, n >= 1);
      end
      s_frame_dv = (n >= 3 && n <= 14);
      tick();
    end
    s_frame_dv = 1'b0;
    exp_fc = 3;
    checks++;
    if (frame_count !== 16'(exp_fc)) begin
      errors++; $display("FAIL sync_fc: got %0d expected %0d", frame_count, exp_fc);
    end
  endtask

  task automatic test_reset_midframe();
    logic [NC*IW-1:0] f1, f2;
    f1 = {24'h333333, 24'h222222, 24'h111111, 24'h0F0F0F};
    f2 = {24'hFFFFFE, 24'h123456, 24'h800000, 24'h654321};
    s_frame_d = f1; s_frame_dv = 1'b1;
    tick();
    s_frame_dv = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({s_frame_ready, vm_signal_dv, vm_sync} !== 3'b000 || vm_signal_d !== '0
        || vm_signal_ch !== '0 || frame_count !== '0) begin
      errors++; $display("FAIL mid_reset: rdy=%b dv=%b sync=%b d=%h ch=%0d fc=%0d expected all 0",
                         s_frame_ready, vm_signal_dv, vm_sync, vm_signal_d, vm_signal_ch, frame_count);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (s_frame_ready !== 1'b1 || vm_signal_dv !== 1'b0 || frame_count !== 16'd0) begin
      errors++; $display("FAIL mid_release: rdy=%b dv=%b fc=%0d expected rdy=1 dv=0 fc=0",
                         s_frame_ready, vm_signal_dv, frame_count);
    end
    s_frame_d = f2; s_frame_dv = 1'b1;
    tick();
    s_frame_dv = 1'b0;
    for (int k = 0; k < NC; k++) begin
      checks++;
      if (vm_signal_dv !== 1'b1 || vm_signal_ch !== 2'(k) || vm_signal_d !== chv(f2, k)) begin
        errors++; $display("FAIL mid_new k=%0d: dv=%b ch=%0d d=%h expected dv=1 ch=%0d d=%h",
                           k, vm_signal_dv, vm_signal_ch, vm_signal_d, k, chv(f2, k));
      end
      tick();
    end
    checks++;
    if (frame_count !== 16'd1) begin
      errors++; $display("FAIL mid_fc: got %0d expected 1", frame_count);
    end
  endtask

  task automatic test_wrap();
    logic [IW1-1:0] v;
    s_frame_dv1 = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      v = 16'(i) ^ 16'h5A5A;
      s_frame_d1 = v;
      tick();
      checks++;
      if (vm_signal_dv1 !== 1'b1 || vm_signal_ch1 !== 1'b0 || vm_signal_d1 !== v
          || s_frame_ready1 !== 1'b1 || frame_count1 !== 16'(i)) begin
        errors++; $display("FAIL one_ch i=%0d: dv=%b ch=%0d d=%h rdy=%b fc=%0d expected dv=1 ch=0 d=%h rdy=1 fc=%0d",
                           i, vm_signal_dv1, vm_signal_ch1, vm_signal_d1, s_frame_ready1, frame_count1, v, i);
      end
    end
    s_frame_dv1 = 1'b0;
    tick();
    checks++;
    if (frame_count1 !== 16'hFFFF || vm_signal_dv1 !== 1'b0) begin
      errors++; $display("FAIL wrap_pre: fc=%h dv=%b expected fc=ffff dv=0", frame_count1, vm_signal_dv1);
    end
    s_frame_d1 = 16'h8001; s_frame_dv1 = 1'b1;
    tick();
    s_frame_dv1 = 1'b0;
    checks++;
    if (vm_signal_dv1 !== 1'b1 || vm_signal_d1 !== 16'h8001 || frame_count1 !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_last: dv=%b d=%h fc=%h expected dv=1 d=8001 fc=ffff",
                         vm_signal_dv1, vm_signal_d1, frame_count1);
    end
    tick();
    checks++;
    if (frame_count1 !== 16'h0000) begin
      errors++; $display("FAIL wrap: fc=%h expected 0000", frame_count1);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_held_frame();
    test_sync();
    test_reset_midframe();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
